// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default bit period.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned UART_DATA_W               = 8;
    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 10417;
    localparam int unsigned UART_STATE_W              = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Even parity bit for a data byte (XOR of all bits).
    function automatic logic uart_even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the wrap cycle.
// clr holds the count at 0 so the first period after release is a full bit.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap at the end of a bit period or clear on request.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick is consumed in the same cycle by the FSM next-state logic.
    assign tick = !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per accepted request, 8N1 LSB first.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit after the data bits).
// TX_STATUS is high while idle and ready; all outputs are registered.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic [UART_DATA_W-1:0] TX_DATA,
    input  logic                   TX_EN,
    output logic                   TX_STATUS,
    output logic                   UART_TX
);

    localparam int unsigned BIT_CNT_W = 3;
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(UART_DATA_W - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP_BIT = BIT_CNT_W'(STOP_BITS - 1);

    logic [UART_STATE_W-1:0] state_q,   state_d;
    logic [UART_DATA_W-1:0]  shift_q,   shift_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                    tx_q,      tx_d;
    logic                    status_q,  status_d;
`ifdef UART_TX_PARITY_EN
    logic                    par_q,     par_d;
`endif
    logic                    baud_tick_c;
    logic                    baud_clr_c;

    // Counter is held at 0 while idle so it restarts on acceptance.
    assign baud_clr_c = (state_q == ST_IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .sysclk (sysclk),
        .reset  (reset),
        .clr    (baud_clr_c),
        .tick   (baud_tick_c)
    );

    // Next-state, shift/bit-count update and registered-output values.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        tx_d      = 1'b1;
        status_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (TX_EN && status_q) begin
                    state_d   = ST_START;
                    shift_d   = TX_DATA;
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    par_d     = uart_even_parity(TX_DATA);
`endif
                end
            end
            ST_START: begin
                if (baud_tick_c) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick_c) begin
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick_c) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick_c) begin
                    if (bit_cnt_q == LAST_STOP_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // Outputs follow the state being entered so they stay registered.
        case (state_d)
            ST_IDLE: begin
                tx_d     = 1'b1;
                status_d = 1'b1;
            end
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            ST_STOP:   tx_d = 1'b1;
            default: begin
                tx_d     = 1'b1;
                status_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and idles the line.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            status_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            status_q  <= status_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign UART_TX   = tx_q;
    assign TX_STATUS = status_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter with a mid-bit line monitor and byte scoreboard.
module tb_uart_transmitter;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB1    = 10 + P;
    localparam int NB2    = 11 + P;
    localparam int FRAME1 = NB1 * CPB;
    localparam int FRAME2 = NB2 * CPB;

    logic       sysclk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_status;
    logic       uart_tx;
    logic [7:0] tx_data2;
    logic       tx_en2;
    logic       tx_status2;
    logic       uart_tx2;

    int         n_checks;
    int         n_fail;
    logic [7:0] sb[$];

    uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .sysclk(sysclk), .reset(reset), .TX_DATA(tx_data), .TX_EN(tx_en),
        .TX_STATUS(tx_status), .UART_TX(uart_tx)
    );

    uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .sysclk(sysclk), .reset(reset), .TX_DATA(tx_data2), .TX_EN(tx_en2),
        .TX_STATUS(tx_status2), .UART_TX(uart_tx2)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    // Line monitor on dut: samples each bit at mid-period, compares whole frames to the scoreboard.
    logic           mon_busy = 1'b0;
    int             mon_cnt  = 0;
    logic [NB1-1:0] mon_bits;
    logic [NB1-1:0] mon_exp;
    logic [7:0]     mon_byte;

    always @(negedge sysclk) begin
        if (reset !== 1'b1) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
            end
        end else begin
            mon_cnt = mon_cnt + 1;
        end
        if (mon_busy && ((mon_cnt % CPB) == (CPB / 2))) begin
            mon_bits[mon_cnt / CPB] = uart_tx;
            if ((mon_cnt / CPB) == (NB1 - 1)) begin
                mon_busy = 1'b0;
                n_checks = n_checks + 1;
                if (sb.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL monitor_unexpected_frame: got line bits %b, required no frame", mon_bits);
                end else begin
                    mon_byte = sb.pop_front();
`ifdef UART_TX_PARITY_EN
                    mon_exp = {1'b1, ^mon_byte, mon_byte, 1'b0};
`else
                    mon_exp = {1'b1, mon_byte, 1'b0};
`endif
                    if (mon_bits !== mon_exp) begin
                        n_fail = n_fail + 1;
                        $display("FAIL monitor_frame: got line bits %b, required %b (byte %h)", mon_bits, mon_exp, mon_byte);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic quiet;
        reset    = 1'b0;
        tx_en    = 1'b1;
        tx_data  = 8'hA5;
        tx_en2   = 1'b1;
        tx_data2 = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (uart_tx !== 1'b1 || tx_status !== 1'b1 || uart_tx2 !== 1'b1 || tx_status2 !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: UART_TX=%b TX_STATUS=%b dut2 %b %b, required all 1", i, uart_tx, tx_status, uart_tx2, tx_status2);
            end
        end
        tx_en  = 1'b0;
        tx_en2 = 1'b0;
        reset  = 1'b1;
        quiet  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (uart_tx !== 1'b1 || tx_status !== 1'b1 || uart_tx2 !== 1'b1 || tx_status2 !== 1'b1) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_idle: idle_flag=%b, required 1", quiet);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0]     b;
        logic [NB1-1:0] fb;
        int             bad;
        b = 8'hA5;
`ifdef UART_TX_PARITY_EN
        fb = {1'b1, ^b, b, 1'b0};
`else
        fb = {1'b1, b, 1'b0};
`endif
        tx_data = b;
        tx_en   = 1'b1;
        sb.push_back(b);
        cyc();
        tx_en = 1'b0;
        n_checks++;
        if (tx_status !== 1'b0 || uart_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept: TX_STATUS=%b UART_TX=%b, required 0 0", tx_status, uart_tx);
        end
        bad = 0;
        for (int k = 0; k < FRAME1; k++) begin
            if (k > 0) cyc();
            if (uart_tx !== fb[k / CPB] || tx_status !== 1'b0) begin
                bad++;
                if (bad == 1) $display("FAIL single_line cycle %0d: UART_TX=%b TX_STATUS=%b, required %b 0", k, uart_tx, tx_status, fb[k / CPB]);
            end
        end
        n_checks++;
        if (bad != 0) n_fail++;
        cyc();
        n_checks++;
        if (tx_status !== 1'b1 || uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL single_status_rise at %0d: TX_STATUS=%b UART_TX=%b, required 1 1", FRAME1, tx_status, uart_tx);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL single_scoreboard: %0d bytes pending, required 0", sb.size());
        end
    endtask

    task automatic test_busy_ignore();
        int   n;
        logic quiet;
        tx_data = 8'h00;
        tx_en   = 1'b1;
        sb.push_back(8'h00);
        cyc();
        tx_en = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        tx_data = 8'hFF;
        tx_en   = 1'b1;
        cyc();
        tx_en = 1'b0;
        n = 11;
        while (tx_status !== 1'b1 && n < 400) begin
            cyc();
            n++;
        end
        n_checks++;
        if (n != FRAME1) begin
            n_fail++;
            $display("FAIL busy_frame_length: %0d cycles, required %0d", n, FRAME1);
        end
        quiet = 1'b1;
        for (int i = 0; i < 3 * FRAME1; i++) begin
            cyc();
            if (uart_tx !== 1'b1 || tx_status !== 1'b1) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_no_second_frame: idle_flag=%b, required 1", quiet);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL busy_scoreboard: %0d bytes pending, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        tx_data = 8'h3C;
        tx_en   = 1'b1;
        sb.push_back(8'h3C);
        sb.push_back(8'h3C);
        cyc();
        n = 0;
        while (tx_status !== 1'b1 && n < 400) begin
            cyc();
            n++;
        end
        n_checks++;
        if (n != FRAME1) begin
            n_fail++;
            $display("FAIL b2b_first_length: %0d cycles, required %0d", n, FRAME1);
        end
        n_checks++;
        if (uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap_high: UART_TX=%b, required 1", uart_tx);
        end
        cyc();
        tx_en = 1'b0;
        n_checks++;
        if (tx_status !== 1'b0 || uart_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_start: TX_STATUS=%b UART_TX=%b, required 0 0", tx_status, uart_tx);
        end
        n = 0;
        while (tx_status !== 1'b1 && n < 400) begin
            cyc();
            n++;
        end
        n_checks++;
        if (n != FRAME1) begin
            n_fail++;
            $display("FAIL b2b_second_length: %0d cycles, required %0d", n, FRAME1);
        end
        cyc();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_scoreboard: %0d bytes pending, required 0", sb.size());
        end
    endtask

    task automatic test_two_stop_bits();
        logic [7:0]     b;
        logic [NB2-1:0] fb;
        int             bad;
        int             n;
        b = 8'h3C;
`ifdef UART_TX_PARITY_EN
        fb = {2'b11, ^b, b, 1'b0};
`else
        fb = {2'b11, b, 1'b0};
`endif
        tx_data2 = b;
        tx_en2   = 1'b1;
        cyc();
        bad = 0;
        for (int k = 0; k < FRAME2; k++) begin
            if (k > 0) cyc();
            if (uart_tx2 !== fb[k / CPB] || tx_status2 !== 1'b0) begin
                bad++;
                if (bad == 1) $display("FAIL stop2_line cycle %0d: UART_TX=%b TX_STATUS=%b, required %b 0", k, uart_tx2, tx_status2, fb[k / CPB]);
            end
        end
        n_checks++;
        if (bad != 0) n_fail++;
        cyc();
        n_checks++;
        if (tx_status2 !== 1'b1 || uart_tx2 !== 1'b1) begin
            n_fail++;
            $display("FAIL stop2_gap: TX_STATUS=%b UART_TX=%b, required 1 1", tx_status2, uart_tx2);
        end
        cyc();
        tx_en2 = 1'b0;
        n_checks++;
        if (tx_status2 !== 1'b0 || uart_tx2 !== 1'b0) begin
            n_fail++;
            $display("FAIL stop2_second_start: TX_STATUS=%b UART_TX=%b, required 0 0", tx_status2, uart_tx2);
        end
        n = 0;
        while (tx_status2 !== 1'b1 && n < 400) begin
            cyc();
            n++;
        end
        n_checks++;
        if (n != FRAME2) begin
            n_fail++;
            $display("FAIL stop2_second_length: %0d cycles, required %0d", n, FRAME2);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        tx_data = 8'h0F;
        tx_en   = 1'b1;
        sb.push_back(8'h0F);
        cyc();
        tx_en = 1'b0;
        for (int k = 1; k <= 17; k++) cyc();
        reset = 1'b0;
        sb.delete();
        cyc();
        n_checks++;
        if (uart_tx !== 1'b1 || tx_status !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_abort: UART_TX=%b TX_STATUS=%b, required 1 1", uart_tx, tx_status);
        end
        reset = 1'b1;
        cyc();
        tx_data = 8'h81;
        tx_en   = 1'b1;
        sb.push_back(8'h81);
        cyc();
        tx_en = 1'b0;
        n = 0;
        while (tx_status !== 1'b1 && n < 400) begin
            cyc();
            n++;
        end
        n_checks++;
        if (n != FRAME1) begin
            n_fail++;
            $display("FAIL reset_mid_new_length: %0d cycles, required %0d", n, FRAME1);
        end
        cyc();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_scoreboard: %0d bytes pending, required 0", sb.size());
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] bytes [2];
        logic       pexp  [2];
        int         n;
        bytes[0] = 8'h07; pexp[0] = 1'b1;
        bytes[1] = 8'h03; pexp[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            tx_data = bytes[t];
            tx_en   = 1'b1;
            sb.push_back(bytes[t]);
            cyc();
            tx_en = 1'b0;
            for (int k = 1; k <= 9 * CPB + CPB / 2; k++) cyc();
            n_checks++;
            if (uart_tx !== pexp[t]) begin
                n_fail++;
                $display("FAIL parity_bit byte %h: UART_TX=%b, required %b", bytes[t], uart_tx, pexp[t]);
            end
            n = 9 * CPB + CPB / 2;
            while (tx_status !== 1'b1 && n < 400) begin
                cyc();
                n++;
            end
            n_checks++;
            if (n != 44) begin
                n_fail++;
                $display("FAIL parity_frame_length byte %h: %0d cycles, required 44", bytes[t], n);
            end
            cyc();
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tx_data  = 8'h00;
        tx_en    = 1'b0;
        tx_data2 = 8'h00;
        tx_en2   = 1'b0;
        reset    = 1'b0;
        test_reset();
        test_single_byte();
        test_busy_ignore();
        test_back_to_back();
        test_two_stop_bits();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        for (int i = 0; i < 2 * FRAME1; i++) cyc();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL final_scoreboard: %0d bytes pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
